// File: rtl/alu_unit.sv
// alu_unit: multi-cycle integer ALU with a ready/valid result handshake.
// ADD/SUB finish in one cycle. MUL (shift-add) and DIV (restoring) each take
// WIDTH iterations, one operand bit per cycle. A one-cycle DONE state pulses
// o_valid before the unit returns to IDLE.
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_cmd,
    output logic [WIDTH-1:0] o_result,
    output logic             o_valid,
    output logic             o_ready
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_ADD = 2'd0,
        CMD_SUB = 2'd1,
        CMD_MUL = 2'd2,
        CMD_DIV = 2'd3
    } cmd_e;

    state_e           state_q, state_d;
    cmd_e             cmd_q, cmd_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    // MUL: acc = partial product, opA = shifted multiplicand, opB = multiplier.
    // DIV: acc = partial remainder, opA = dividend shifting out / quotient
    // shifting in, opB = divisor (held).
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;

    logic [WIDTH-1:0] mulAcc;
    logic [WIDTH:0]   divTrial;
    logic [WIDTH-1:0] divDiff;
    logic             divOk;

    // State register; a low reset aborts any operation and clears the result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cmd_q    <= CMD_ADD;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            acc_q    <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            ready_q  <= ready_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
        end
    end

    // Single iteration datapaths for MUL and DIV; remainder stays below the
    // divisor, so a successful trial subtraction always fits in WIDTH bits.
    always_comb begin
        mulAcc   = opB_q[0] ? (acc_q + opA_q) : acc_q;
        divTrial = {acc_q, opA_q[WIDTH-1]};
        divOk    = (divTrial >= {1'b0, opB_q});
        divDiff  = divTrial[WIDTH-1:0] - opB_q;
    end

    // Next-state logic: capture in IDLE, iterate in BUSY, pulse in DONE.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        acc_d    = acc_q;
        opA_d    = opA_q;
        opB_d    = opB_q;

        case (state_q)
            IDLE: begin
                if (ready_q) begin
                    cmd_d = cmd_e'(i_cmd);
                    case (cmd_e'(i_cmd))
                        CMD_ADD: begin
                            result_d = i_a + i_b;
                            state_d  = DONE;
                        end
                        CMD_SUB: begin
                            result_d = i_a - i_b;
                            state_d  = DONE;
                        end
                        default: begin
                            acc_d   = '0;
                            opA_d   = i_a;
                            opB_d   = i_b;
                            cnt_d   = '0;
                            state_d = BUSY;
                        end
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (cmd_q == CMD_MUL) begin
                    acc_d = mulAcc;
                    opA_d = opA_q << 1;
                    opB_d = opB_q >> 1;
                end else begin
                    acc_d = divOk ? divDiff : divTrial[WIDTH-1:0];
                    opA_d = {opA_q[WIDTH-2:0], divOk};
                end
                if (cnt_q == LAST_STEP) begin
                    state_d  = DONE;
                    result_d = (cmd_q == CMD_MUL) ? mulAcc
                                                  : {opA_q[WIDTH-2:0], divOk};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    assign o_result = result_q;
    assign o_valid  = (state_q == DONE);
    assign o_ready  = ready_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and randomized checks of alu_unit against an
// arithmetic reference model.
module tb_alu_unit;

    localparam int WIDTH    = 32;
    localparam int MAX_WAIT = WIDTH + 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [1:0]       i_cmd;
    logic [WIDTH-1:0] o_result;
    logic             o_valid;
    logic             o_ready;

    int compareCount = 0;
    int errorCount   = 0;
    logic [WIDTH-1:0] lastResult = '0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    alu_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_cmd    (i_cmd),
        .o_result (o_result),
        .o_valid  (o_valid),
        .o_ready  (o_ready)
    );

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model written directly from the arithmetic rules.
    function automatic logic [WIDTH-1:0] refResult(input logic [1:0] cmd,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        longint unsigned prod;
        case (cmd)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: begin
                prod = longint'({32'd0, a}) * longint'({32'd0, b});
                return prod[WIDTH-1:0];
            end
            default: return (b == 0) ? {WIDTH{1'b1}} : (a / b);
        endcase
    endfunction

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag,
                               input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        compareCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Wait (bounded) at negedges until the unit reports ready.
    task automatic waitReady(output bit ok);
        int n;
        n = 0;
        while (o_ready !== 1'b1 && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        ok = (o_ready === 1'b1);
    endtask

    // Issue one operation, scramble inputs while busy, and check the result,
    // latency and handshake behaviour.
    task automatic applyStimulus(input logic [1:0] cmd,
                                 input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input string tag);
        bit               ok;
        int               cycles;
        bit               readyLow;
        bit               resultHeld;
        int               expLat;
        logic [WIDTH-1:0] expected;

        expected = refResult(cmd, a, b);
        expLat   = cmd[1] ? WIDTH + 1 : 1;

        waitReady(ok);
        if (!ok) begin
            checkOutput({tag, "_readyTimeout"}, 32'd0, 32'd1);
            return;
        end
        i_a   = a;
        i_b   = b;
        i_cmd = cmd;

        cycles     = 0;
        readyLow   = 1'b1;
        resultHeld = 1'b1;
        do begin
            @(negedge clk);
            cycles++;
            if (o_valid !== 1'b1) begin
                if (o_ready !== 1'b0) readyLow = 1'b0;
                if (o_result !== lastResult) resultHeld = 1'b0;
            end
            i_a   = $urandom;
            i_b   = $urandom;
            i_cmd = 2'($urandom);
        end while (o_valid !== 1'b1 && cycles < MAX_WAIT);

        checkOutput({tag, "_latency"}, 32'(cycles), 32'(expLat));
        checkOutput({tag, "_result"}, o_result, expected);
        checkOutput({tag, "_readyLowBusy"}, 32'(readyLow), 32'd1);
        checkOutput({tag, "_resultHeldBusy"}, 32'(resultHeld), 32'd1);
        checkOutput({tag, "_readyAtValid"}, 32'(o_ready), 32'd0);

        @(negedge clk);
        checkOutput({tag, "_readyAfter"}, 32'(o_ready), 32'd1);
        checkOutput({tag, "_validAfter"}, 32'(o_valid), 32'd0);
        checkOutput({tag, "_resultStable"}, o_result, expected);
        lastResult = expected;
    endtask

    initial begin
        bit ok;
        bit noValid;
        logic [1:0]       rCmd;
        logic [WIDTH-1:0] rA;
        logic [WIDTH-1:0] rB;

        reset = 1'b0;
        i_a   = '0;
        i_b   = '0;
        i_cmd = 2'd0;

        repeat (2) begin
            @(negedge clk);
            checkOutput("resetReady", 32'(o_ready), 32'd0);
            checkOutput("resetValid", 32'(o_valid), 32'd0);
            checkOutput("resetResult", o_result, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("releaseReady", 32'(o_ready), 32'd1);
        checkOutput("releaseValid", 32'(o_valid), 32'd0);

        applyStimulus(2'd0, 32'hFFFF_FFFF, 32'd2, "addWrap");
        applyStimulus(2'd1, 32'd5, 32'd7, "subNeg");
        applyStimulus(2'd1, 32'h10, 32'h10, "subZero");
        applyStimulus(2'd1, 32'd0, 32'd1, "subUnderflow");
        applyStimulus(2'd2, 32'h0001_0001, 32'h0001_0001, "mulBasic");
        applyStimulus(2'd2, 32'h8000_0000, 32'd2, "mulOverflow");
        applyStimulus(2'd3, 32'd100, 32'd7, "divBasic");
        applyStimulus(2'd3, 32'd9, 32'd0, "divByZero");
        applyStimulus(2'd3, 32'hFFFF_FFFF, 32'd1, "divByOne");
        applyStimulus(2'd3, 32'd3, 32'hFFFF_FFFF, "divSmall");

        // Abort a multiply 10 cycles in with a one-cycle reset pulse.
        waitReady(ok);
        checkOutput("abortReadyStart", 32'(ok), 32'd1);
        i_a   = 32'h1234_5678;
        i_b   = 32'h0000_0F0F;
        i_cmd = 2'd2;
        noValid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (o_valid !== 1'b0) noValid = 1'b0;
        end
        checkOutput("abortNoEarlyValid", 32'(noValid), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abortValid", 32'(o_valid), 32'd0);
        checkOutput("abortResult", o_result, 32'd0);
        checkOutput("abortReady", 32'(o_ready), 32'd0);
        reset = 1'b1;
        lastResult = '0;
        @(negedge clk);
        checkOutput("abortReadyAfter", 32'(o_ready), 32'd1);
        checkOutput("abortValidAfter", 32'(o_valid), 32'd0);
        applyStimulus(2'd2, 32'd123, 32'd456, "postAbortMul");

        // Randomized operations, with small and zero divisors mixed in.
        for (int n = 0; n < 40; n++) begin
            rCmd = 2'($urandom);
            rA   = $urandom;
            case ($urandom_range(0, 3))
                0:       rB = 32'($urandom_range(0, 20));
                1:       rB = $urandom >> $urandom_range(0, 31);
                default: rB = $urandom;
            endcase
            applyStimulus(rCmd, rA, rB, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end

endmodule
